dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single DRAM controller port between two requesters: CPU (single-word read/write) and VGA (32-word burst read).
//  Sits between the memory map / VGA fetch logic and the DRAM controller.
//  Arbitrates, issues one start strobe per transaction and waits for dram_data_ready.
//  Returns an ack (plus read data for the CPU) and aborts hung transactions after a timeout.
// PARAMETERS
//  TIMEOUT      64   max WAIT cycles before abort; 6-bit counter, legal 2..63 (64 = saturate at 63)
//  ERR_RDATA    16'hFFFF  cpu_rdata value returned on a timed-out CPU read
// PORTS
//  clk              in   1   system clock
//  rst              in   1   synchronous reset, active-high
//  cpu_req          in   1   CPU transaction request; hold until cpu_ack
//  cpu_we           in   1   1 = write, 0 = read; sampled with cpu_req
//  cpu_addr         in   25  CPU word address
//  cpu_wdata        in   16  CPU write data
//  cpu_ack          out  1   one-cycle pulse: CPU transaction complete
//  cpu_rdata        out  16  CPU read data; valid while cpu_ack=1, held afterwards
//  vga_req          in   1   VGA burst request; hold until vga_ack
//  vga_urgent       in   1   VGA line buffer nearly empty: VGA wins any tie
//  vga_addr         in   25  burst base address; bits [4:0] ignored (forced 0)
//  vga_ack          out  1   one-cycle pulse: burst data valid in the DRAM burst buffer
//  dram_addr        out  25  address to DRAM controller
//  dram_write_en    out  1   write enable to DRAM controller
//  dram_burst_en    out  1   burst read select to DRAM controller
//  dram_data_in     out  16  write data to DRAM controller
//  dram_refresh_data out 1   one-cycle start strobe to DRAM controller
//  dram_data_ready  in   1   DRAM controller completion
//  dram_read_data   in   16  DRAM single-word read data
//  timeout_err      out  1   one-cycle pulse when a transaction is aborted
//  busy             out  1   1 in every state except IDLE
// BEHAVIOUR
//  States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  Reset (rst=1 at posedge): state=IDLE; every output 0 (dram_addr, cpu_rdata included); wait_cnt=0; last_grant=VGA.
//  Reset mid-transaction: abort immediately; no ack or err pulse; the strobe drops the next cycle.
//  IDLE: reqs sampled. Winner:
//   - only one req high: that requester.
//   - both high: VGA if vga_urgent; else the requester not equal to last_grant.
//   - On a grant: latch dram_addr, dram_write_en (cpu_we, or 0 for VGA), dram_burst_en (1 for VGA, 0 for CPU), dram_data_in (cpu_wdata for CPU); set last_grant; go ISSUE.
//   - VGA dram_addr = {vga_addr[24:5],5'b0}.
//  ISSUE: dram_refresh_data=1 for exactly this cycle; wait_cnt=0; go WAIT.
//   - dram_data_ready is ignored in ISSUE.
//  WAIT: wait_cnt+=1 each cycle.
//   - dram_data_ready=1: capture dram_read_data into cpu_rdata (CPU read only); go DONE.
//   - else if wait_cnt==TIMEOUT-1: set abort flag; cpu_rdata=ERR_RDATA for a CPU read; go DONE.
//   - ready and timeout in the same cycle: ready wins, no error.
//  DONE: the winner's ack=1 for one cycle; timeout_err=1 if aborted; dram_write_en and dram_burst_en cleared; go IDLE.
//  dram_addr and dram_data_in hold their last value outside a transaction.
//  Latency: grant in IDLE cycle T -> strobe in T+1 -> earliest ready T+2 -> ack T+3 (4-cycle minimum per transaction).
//  Handshake:
//   - A req that drops mid-transaction does not cancel it; the ack still pulses.
//   - A req still high in the IDLE cycle after its ack is a new request.
//   - Inputs are sampled only in IDLE; changes during ISSUE/WAIT/DONE have no effect on the current transaction.
//  CPU writes: cpu_rdata is unchanged.
//  Both reqs held continuously without urgent: strict CPU/VGA alternation.
// TESTING
//  1. Reset, then cpu_req read addr 0x00123, ready 3 cycles after strobe, read_data 0xBEEF -> one strobe, cpu_ack 1 cycle, cpu_rdata=0xBEEF, burst_en=0.
//  2. CPU write addr 0x0040 data 0x1234 -> dram_write_en=1, dram_data_in=0x1234 at strobe; cpu_ack; cpu_rdata unchanged.
//  3. Both reqs held, urgent=0, 4 transactions -> grant order CPU,VGA,CPU,VGA; VGA dram_addr low 5 bits = 0, burst_en=1.
//  4. Both reqs held, last_grant=VGA, vga_urgent=1 -> VGA granted again.
//  5. CPU read, ready never asserted -> after TIMEOUT WAIT cycles: cpu_ack and timeout_err in the same cycle, cpu_rdata=0xFFFF.
//  6. rst=1 during WAIT of a VGA burst -> no vga_ack; busy=0 the next cycle; the next CPU req is served normally.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one DRAM controller port between CPU single-word
// accesses and VGA 32-word burst reads, with a per-transaction timeout.
module dram_arbiter #(
   parameter int          TIMEOUT   = 64,
   parameter logic [15:0] ERR_RDATA = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [24:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   input  logic        vga_req,
   input  logic        vga_urgent,
   input  logic [24:0] vga_addr,
   output logic        vga_ack,
   output logic [24:0] dram_addr,
   output logic        dram_write_en,
   output logic        dram_burst_en,
   output logic [15:0] dram_data_in,
   output logic        dram_refresh_data,
   input  logic        dram_data_ready,
   input  logic [15:0] dram_read_data,
   output logic        timeout_err,
   output logic        busy
);

   // Last WAIT count before abort; a 64-cycle budget saturates the counter.
   localparam logic [5:0] LIMIT =
      (TIMEOUT >= 64) ? 6'd63 : 6'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        grant_cpu;
   logic        grant_vga;
   logic        last_vga;
   logic        cur_vga;
   logic        cur_read;
   logic        aborted;
   logic [5:0]  wait_cnt;
   logic        wait_end;
   logic        time_hit;
   logic [24:0] vga_base;

   // Bursts always start on a 32-word boundary.
   assign vga_base = vga_addr & ~25'h1F;

   assign time_hit = (wait_cnt == LIMIT);
   assign wait_end = dram_data_ready | time_hit;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Arbitration, next state and per-state output pulses.
   always_comb begin
      state_nx          = state;
      grant_cpu         = 1'b0;
      grant_vga         = 1'b0;
      dram_refresh_data = 1'b0;
      cpu_ack           = 1'b0;
      vga_ack           = 1'b0;
      timeout_err       = 1'b0;
      busy              = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (cpu_req && vga_req) begin
               if (vga_urgent || !last_vga) begin
                  grant_vga = 1'b1;
               end else begin
                  grant_cpu = 1'b1;
               end
            end else if (cpu_req) begin
               grant_cpu = 1'b1;
            end else if (vga_req) begin
               grant_vga = 1'b1;
            end
            if (grant_cpu || grant_vga) begin
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            dram_refresh_data = 1'b1;
            state_nx          = WAIT;
         end
         WAIT: begin
            if (wait_end) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            cpu_ack     = ~cur_vga;
            vga_ack     = cur_vga;
            timeout_err = aborted;
            state_nx    = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Latch the granted request into the controller command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dram_addr     <= '0;
         dram_write_en <= 1'b0;
         dram_burst_en <= 1'b0;
         dram_data_in  <= '0;
         last_vga      <= 1'b1;
         cur_vga       <= 1'b0;
         cur_read      <= 1'b0;
      end else begin
         if (grant_cpu) begin
            dram_addr     <= cpu_addr;
            dram_write_en <= cpu_we;
            dram_burst_en <= 1'b0;
            dram_data_in  <= cpu_wdata;
            last_vga      <= 1'b0;
            cur_vga       <= 1'b0;
            cur_read      <= ~cpu_we;
         end else if (grant_vga) begin
            dram_addr     <= vga_base;
            dram_write_en <= 1'b0;
            dram_burst_en <= 1'b1;
            last_vga      <= 1'b1;
            cur_vga       <= 1'b1;
            cur_read      <= 1'b0;
         end else if (state == WAIT && wait_end) begin
            dram_write_en <= 1'b0;
            dram_burst_en <= 1'b0;
         end
      end
   end

   // WAIT cycle counter and abort flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         aborted  <= 1'b0;
      end else if (state == ISSUE) begin
         wait_cnt <= '0;
         aborted  <= 1'b0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 6'd1;
         if (!dram_data_ready && time_hit) begin
            aborted <= 1'b1;
         end
      end
   end

   // CPU read data: captured on ready, error pattern on abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata <= '0;
      end else if (state == WAIT && cur_read) begin
         if (dram_data_ready) begin
            cpu_rdata <= dram_read_data;
         end else if (time_hit) begin
            cpu_rdata <= ERR_RDATA;
         end
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and randomized transactions against a
// transaction-level model of the arbiter.
module tb_dram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [24:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        vga_req;
   logic        vga_urgent;
   logic [24:0] vga_addr;
   logic        vga_ack;
   logic [24:0] dram_addr;
   logic        dram_write_en;
   logic        dram_burst_en;
   logic [15:0] dram_data_in;
   logic        dram_refresh_data;
   logic        dram_data_ready;
   logic [15:0] dram_read_data;
   logic        timeout_err;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   bit          m_last_vga;
   logic [15:0] m_rdata;
   logic [15:0] m_din;

   localparam int BUDGET = 64;

   dram_arbiter #(
      .TIMEOUT   (64),
      .ERR_RDATA (16'hFFFF)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .cpu_req           (cpu_req),
      .cpu_we            (cpu_we),
      .cpu_addr          (cpu_addr),
      .cpu_wdata         (cpu_wdata),
      .cpu_ack           (cpu_ack),
      .cpu_rdata         (cpu_rdata),
      .vga_req           (vga_req),
      .vga_urgent        (vga_urgent),
      .vga_addr          (vga_addr),
      .vga_ack           (vga_ack),
      .dram_addr         (dram_addr),
      .dram_write_en     (dram_write_en),
      .dram_burst_en     (dram_burst_en),
      .dram_data_in      (dram_data_in),
      .dram_refresh_data (dram_refresh_data),
      .dram_data_ready   (dram_data_ready),
      .dram_read_data    (dram_read_data),
      .timeout_err       (timeout_err),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction, entered and left on an IDLE-cycle negedge.
   // k = WAIT cycle (1-based) carrying ready; k > 64 means never ready.
   task automatic txn(input bit creq, input bit cwe,
                      input logic [24:0] caddr, input logic [15:0] cwd,
                      input bit vreq, input bit urg,
                      input logic [24:0] vaddr,
                      input int k, input logic [15:0] rd,
                      input bit drop);
      bit          win_vga;
      bit          to;
      int          e;
      logic [24:0] e_addr;
      logic [31:0] bad;
      cpu_req    = creq;
      cpu_we     = cwe;
      cpu_addr   = caddr;
      cpu_wdata  = cwd;
      vga_req    = vreq;
      vga_urgent = urg;
      vga_addr   = vaddr;
      dram_data_ready = 1'b0;
      if (!creq && !vreq) begin
         @(negedge clk);
         chk("idle_busy", busy, 0);
         chk("idle_strobe", dram_refresh_data, 0);
         return;
      end
      if (creq && vreq) win_vga = urg || !m_last_vga;
      else win_vga = vreq;
      m_last_vga = win_vga;
      e_addr = win_vga ? {vaddr[24:5], 5'd0} : caddr;
      if (!win_vga) m_din = cwd;
      to = (k > BUDGET);
      e  = (to ? BUDGET : k) + 1;
      @(negedge clk);
      chk("strobe", dram_refresh_data, 1);
      chk("addr", dram_addr, e_addr);
      chk("we", dram_write_en, !win_vga && cwe);
      chk("burst", dram_burst_en, win_vga);
      chk("din", dram_data_in, m_din);
      dram_data_ready = 1'($urandom_range(1));
      if (drop) begin
         cpu_req  = 1'b0;
         vga_req  = 1'b0;
         cpu_we   = ~cwe;
         cpu_addr = 25'($urandom);
         vga_addr = 25'($urandom);
      end
      bad = 0;
      for (int j = 1; j <= e; j++) begin
         @(negedge clk);
         if (j < e) begin
            if (cpu_ack || vga_ack || timeout_err) bad = bad | 1;
            if (dram_refresh_data || !busy) bad = bad | 2;
            dram_data_ready = (j == k);
            dram_read_data  = (j == k) ? rd : 16'($urandom);
         end
      end
      dram_data_ready = 1'b0;
      if (!win_vga && !cwe) m_rdata = to ? 16'hFFFF : rd;
      chk("no_early", bad, 0);
      chk("cpu_ack", cpu_ack, !win_vga);
      chk("vga_ack", vga_ack, win_vga);
      chk("terr", timeout_err, to);
      chk("rdata", cpu_rdata, m_rdata);
      chk("we_clr", {dram_write_en, dram_burst_en}, 0);
      chk("addr_hold", dram_addr, e_addr);
      if (drop) begin
         cpu_req = 1'b0;
         vga_req = 1'b0;
      end
      @(negedge clk);
      chk("ack_pulse", {cpu_ack, vga_ack, timeout_err}, 0);
      chk("idle", {busy, dram_refresh_data}, 0);
      chk("rdata_hold", cpu_rdata, m_rdata);
   endtask

   initial begin
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      vga_req = 0; vga_urgent = 0; vga_addr = 0;
      dram_data_ready = 0; dram_read_data = 0;
      m_last_vga = 1'b1;
      m_rdata = 0;
      m_din = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_pulses",
          {cpu_ack, vga_ack, timeout_err, dram_refresh_data, busy}, 0);
      chk("rst_cmd", {dram_write_en, dram_burst_en}, 0);
      chk("rst_addr", dram_addr, 0);
      chk("rst_din", dram_data_in, 0);
      chk("rst_rdata", cpu_rdata, 0);

      // CPU read, ready three cycles after the strobe.
      txn(1, 0, 25'h00123, 16'h5A5A, 0, 0, 0, 3, 16'hBEEF, 1);
      // CPU write leaves read data alone.
      txn(1, 1, 25'h00040, 16'h1234, 0, 0, 0, 2, 16'h7777, 1);
      // VGA only, unaligned base.
      txn(0, 0, 0, 0, 1, 0, 25'h1ABCDEF, 1, 0, 1);
      // Both held without urgency: alternation.
      for (int i = 0; i < 4; i++)
         txn(1, 0, 25'h100 + 25'(i), 16'(i), 1, 0,
             25'h0AAAA5F + 25'(i), 1 + i, 16'hC000 + 16'(i), 0);
      // Urgent VGA wins even right after a VGA grant.
      txn(1, 0, 25'h200, 0, 1, 1, 25'h0333333, 2, 16'h1111, 1);
      // CPU read that never completes.
      txn(1, 0, 25'h300, 0, 0, 0, 0, 65, 16'h2222, 1);
      // Ready on the last possible WAIT cycle beats the timeout.
      txn(1, 0, 25'h301, 0, 0, 0, 0, 64, 16'h3333, 1);
      // VGA timeout.
      txn(0, 0, 0, 0, 1, 0, 25'h0000040, 65, 0, 1);

      // Reset in the middle of a VGA burst.
      vga_req  = 1'b1;
      vga_addr = 25'h0123456;
      @(negedge clk);
      chk("r6_strobe", dram_refresh_data, 1);
      vga_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last_vga = 1'b1;
      m_rdata = 0;
      m_din = 0;
      chk("r6_pulses",
          {vga_ack, cpu_ack, timeout_err, dram_refresh_data, busy}, 0);
      chk("r6_addr", dram_addr, 0);
      chk("r6_rdata", cpu_rdata, 0);
      @(negedge clk);
      chk("r6_noack", {vga_ack, timeout_err, busy}, 0);
      txn(1, 0, 25'h0ABCDE, 0, 0, 0, 0, 1, 16'h4321, 1);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         int k;
         int r;
         r = int'($urandom_range(7));
         case (r)
            0: k = 1;
            1: k = 2;
            2: k = 64;
            3: k = 65;
            default: k = 1 + int'($urandom_range(5));
         endcase
         txn(1'($urandom_range(1)), 1'($urandom_range(1)),
             25'($urandom), 16'($urandom),
             1'($urandom_range(1)), 1'($urandom_range(1)),
             25'($urandom), k, 16'($urandom),
             1'($urandom_range(1)));
      end
      cpu_req = 1'b0;
      vga_req = 1'b0;
      @(negedge clk);
      chk("end_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
